pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the in-order core. It sits beside the fetch/decode/exec/writeback stages.
//  It turns exec-stage jump/branch/fence.i outcomes, decode-vs-exec load-use hazards and data-memory
//  wait states into PC redirect, stall, flush and bubble controls.
//  It is the single owner of every stall and flush decision; stages never stall themselves.
// PARAMETERS
//  FLUSH_CYCLES   2     cycles flush_id/bubble_ex stay high per redirect (detect cycle included), >=1
//  LU_CYCLES      1     bubble cycles per load-use hazard (detect cycle included), >=1
//  MEM_TIMEOUT    255   MEM_WAIT cycles before mem_err sets; 0 disables the timeout
// PORTS
//  clk          in   1   core clock
//  rst_n        in   1   asynchronous, active-low reset
//  ex_valid     in   1   exec holds a valid instruction
//  ex_pc        in   32  PC of the exec instruction
//  ex_jump      in   1   exec instruction is JAL/JALR
//  ex_branch    in   1   exec branch resolved taken
//  ex_fence_i   in   1   exec instruction is FENCE.I
//  ex_target    in   32  jump/branch target computed by exec
//  ex_is_load   in   1   exec instruction is a load
//  ex_rd        in   5   exec destination register
//  id_valid     in   1   decode holds a valid instruction
//  id_rs1       in   5   decode source register 1
//  id_rs2       in   5   decode source register 2
//  id_use_rs1   in   1   decode instruction reads rs1
//  id_use_rs2   in   1   decode instruction reads rs2
//  dmem_req     in   1   exec/dmem issues a memory access this cycle
//  dmem_ready   in   1   data memory completes the access this cycle
//  pc_redirect  out  1   fetch loads pc_target next edge
//  pc_target    out  32  redirect PC, bit0 forced 0
//  stall_if     out  1   fetch holds PC
//  stall_id     out  1   decode register holds
//  stall_ex     out  1   exec register holds
//  flush_id     out  1   decode register loads a NOP
//  bubble_ex    out  1   exec register loads a NOP
//  mem_err      out  1   sticky: MEM_WAIT timeout expired
// BEHAVIOUR
//  - Reset: state=RUN, counters=0, mem_err=0. All outputs are 0 while rst_n=0; pc_target=0.
//  - Outputs are Mealy (combinational from state+inputs); state and counters update on posedge clk.
//  - RUN priority, highest first:
//    1 mem: ex_valid&dmem_req&!dmem_ready -> stall_if/id/ex=1; next MEM_WAIT; tmo_cnt=1.
//    2 redirect: ex_valid&(ex_jump|ex_branch|ex_fence_i) -> pc_redirect=1, flush_id=1, bubble_ex=1.
//      pc_target = ex_fence_i ? ex_pc+4 : {ex_target[31:1],1'b0}.
//      If FLUSH_CYCLES>1: next FLUSH, fl_cnt=FLUSH_CYCLES-1.
//    3 load-use: ex_valid&ex_is_load&ex_rd!=0&id_valid&((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd))
//      -> stall_if=1, stall_id=1, bubble_ex=1. If LU_CYCLES>1: next LU_STALL, lu_cnt=LU_CYCLES-1.
//  - FLUSH: flush_id=1, bubble_ex=1, pc_redirect=0. Exec inputs are ignored. fl_cnt-- ; fl_cnt==1 -> RUN.
//  - LU_STALL: stall_if=1, stall_id=1, bubble_ex=1. lu_cnt-- ; lu_cnt==1 -> RUN.
//  - MEM_WAIT: stall_if/id/ex = !dmem_ready. dmem_ready=1 -> RUN next edge; the instruction advances
//    on that edge. Redirect/load-use raised by the waiting instruction is evaluated in RUN on the next cycle.
//  - Timeout: tmo_cnt increments in MEM_WAIT and saturates at all-ones. If tmo_cnt==MEM_TIMEOUT and
//    MEM_TIMEOUT!=0, mem_err=1 (sticky until reset); the stall continues.
//  - Redirect and load-use in the same cycle: the redirect wins; the load-use stall is dropped
//    because the decode instruction is flushed.
//  - Reset mid-FLUSH/LU_STALL/MEM_WAIT: immediate return to RUN with outputs 0; counters clear.
//  - x0 destination never creates a load-use hazard.
// CONFIGURATION
//  - PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
//    They wrap modulo 2^32 and reset to 0.
//    perf_stall_cnt +1 every cycle stall_if=1; perf_flush_cnt +1 per RUN-state redirect (not per FLUSH cycle).
//  - Undefined: neither port nor counter exists. Control behaviour is identical either way.
// STRUCTURE
//  - defs package: pipe_ctrl_state_e {RUN, FLUSH, LU_STALL, MEM_WAIT}, NOP_INSTR constant, REG_ADDR_W=5.
//  - Sub-module: load_use_detect (combinational comparator producing the load-use hit); the FSM and
//    counters stay in pipe_ctrl.
//  - Counter widths: $clog2(param+1), at least 1.
// TESTING
//  1 BEQ taken: ex_valid=1, ex_branch=1, ex_target=32'h0000_0101 -> same cycle pc_redirect=1,
//    pc_target=32'h100, flush_id=1 for 2 cycles (FLUSH_CYCLES=2), then RUN.
//  2 Load-use: ex_is_load=1, ex_rd=5; id_rs2=5, id_use_rs2=1 -> stall_if=stall_id=bubble_ex=1 one cycle.
//    Same with ex_rd=0 -> no stall.
//  3 MEM_WAIT: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> stall_ex high 3 cycles and low on the
//    ready cycle; state RUN after that edge.
//  4 Timeout: MEM_TIMEOUT=4, ready held 0 for 10 cycles -> mem_err rises after the 4th MEM_WAIT cycle,
//    stays 1; cleared only by rst_n=0.
//  5 Simultaneous: JAL plus load-use match in one cycle -> pc_redirect=1, stall_if=0, flush_id=1.
//    FENCE.I at ex_pc=32'h40 -> pc_target=32'h44.
//  6 rst_n low mid-FLUSH -> all outputs 0 asynchronously; after release a plain instruction gives no
//    stall/flush. With PIPE_CTRL_PERF_EN, counts match cases 1-3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, register-address width,
// the canonical NOP encoding and the counter-width helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    LU_STALL,
    MEM_WAIT
  } pipe_ctrl_state_e;

  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-facing bundle of the pipeline sequencer: exec/decode/dmem status in, PC redirect
// and stall/flush/bubble controls out. master = pipeline stages, slave = pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                  ex_valid;
  logic [31:0]           ex_pc;
  logic                  ex_jump;
  logic                  ex_branch;
  logic                  ex_fence_i;
  logic [31:0]           ex_target;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  pc_redirect;
  logic [31:0]           pc_target;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  flush_id;
  logic                  bubble_ex;
  logic                  mem_err;

  modport master (
    output ex_valid, ex_pc, ex_jump, ex_branch, ex_fence_i, ex_target, ex_is_load, ex_rd,
           id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, dmem_req, dmem_ready,
    input  pc_redirect, pc_target, stall_if, stall_id, stall_ex, flush_id, bubble_ex, mem_err
  );

  modport slave (
    input  ex_valid, ex_pc, ex_jump, ex_branch, ex_fence_i, ex_target, ex_is_load, ex_rd,
           id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, dmem_req, dmem_ready,
    output pc_redirect, pc_target, stall_if, stall_id, stall_ex, flush_id, bubble_ex, mem_err
  );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in exec whose destination is read by the
// instruction currently in decode.
module pipe_ctrl_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hard-wired to zero, so a load targeting it never feeds a later reader.
  assign hit = ex_valid && ex_is_load && (ex_rd != '0) && id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: sole owner of PC redirect, stall, flush and bubble decisions.
// Optional PIPE_CTRL_PERF_EN adds perf_stall_cnt / perf_flush_cnt event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam int LW = cnt_width(LU_CYCLES);
  localparam int TW = cnt_width(MEM_TIMEOUT);

  localparam logic [FW-1:0] FL_LOAD   = FW'(FLUSH_CYCLES - 1);
  localparam logic [LW-1:0] LU_LOAD   = LW'(LU_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MATCH = TW'(MEM_TIMEOUT);

  pipe_ctrl_state_e state;
  logic [FW-1:0]    fl_cnt;
  logic [LW-1:0]    lu_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             mem_err_q;

  logic mem_miss;
  logic redirect_req;
  logic lu_hit;
  logic [31:0] target_raw;

  logic pc_redirect_c;
  logic stall_if_c;
  logic stall_id_c;
  logic stall_ex_c;
  logic flush_id_c;
  logic bubble_ex_c;

  pipe_ctrl_load_use_detect u_load_use_detect (
    .ex_valid   (bus.ex_valid),
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .hit        (lu_hit)
  );

  assign mem_miss     = bus.ex_valid && bus.dmem_req && !bus.dmem_ready;
  assign redirect_req = bus.ex_valid && (bus.ex_jump || bus.ex_branch || bus.ex_fence_i);
  assign target_raw   = bus.ex_fence_i ? (bus.ex_pc + 32'd4) : bus.ex_target;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    pc_redirect_c = 1'b0;
    stall_if_c    = 1'b0;
    stall_id_c    = 1'b0;
    stall_ex_c    = 1'b0;
    flush_id_c    = 1'b0;
    bubble_ex_c   = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
        end else if (redirect_req) begin
          // A redirect flushes decode, which also removes any load-use consumer there.
          pc_redirect_c = 1'b1;
          flush_id_c    = 1'b1;
          bubble_ex_c   = 1'b1;
        end else if (lu_hit) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
      end
      FLUSH: begin
        flush_id_c  = 1'b1;
        bubble_ex_c = 1'b1;
      end
      LU_STALL: begin
        stall_if_c  = 1'b1;
        stall_id_c  = 1'b1;
        bubble_ex_c = 1'b1;
      end
      MEM_WAIT: begin
        stall_if_c = !bus.dmem_ready;
        stall_id_c = !bus.dmem_ready;
        stall_ex_c = !bus.dmem_ready;
      end
    endcase
  end

  // Outputs are Mealy, so they are forced low combinationally while reset is held.
  assign bus.pc_redirect = rst_n && pc_redirect_c;
  assign bus.pc_target   = (rst_n && pc_redirect_c) ? (target_raw & 32'hFFFF_FFFE) : '0;
  assign bus.stall_if    = rst_n && stall_if_c;
  assign bus.stall_id    = rst_n && stall_id_c;
  assign bus.stall_ex    = rst_n && stall_ex_c;
  assign bus.flush_id    = rst_n && flush_id_c;
  assign bus.bubble_ex   = rst_n && bubble_ex_c;
  assign bus.mem_err     = mem_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fl_cnt    <= '0;
      lu_cnt    <= '0;
      tmo_cnt   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            state   <= MEM_WAIT;
            tmo_cnt <= TW'(1);
          end else if (redirect_req) begin
            if (FLUSH_CYCLES > 1) begin
              state  <= FLUSH;
              fl_cnt <= FL_LOAD;
            end
          end else if (lu_hit) begin
            if (LU_CYCLES > 1) begin
              state  <= LU_STALL;
              lu_cnt <= LU_LOAD;
            end
          end
        end
        FLUSH: begin
          fl_cnt <= fl_cnt - FW'(1);
          if (fl_cnt == FW'(1)) state <= RUN;
        end
        LU_STALL: begin
          lu_cnt <= lu_cnt - LW'(1);
          if (lu_cnt == LW'(1)) state <= RUN;
        end
        MEM_WAIT: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TW'(1);
          if ((MEM_TIMEOUT != 0) && (tmo_cnt == TMO_MATCH)) mem_err_q <= 1'b1;
          // The waiting instruction advances on this edge; its redirect/hazard is seen in RUN.
          if (bus.dmem_ready) state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if_c)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_redirect_c) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all compared against a
// cycle-level behavioural model that tracks pending flush/stall cycles as plain integers.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int LU_CYCLES    = 1;
  localparam int MEM_TIMEOUT  = 4;

  typedef struct packed {
    logic pc_redirect;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic flush_id;
    logic bubble_ex;
    logic mem_err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .LU_CYCLES    (LU_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: cycles still owed to a flush / load-use stall, and memory-wait progress.
  int          m_flush_left;
  int          m_lu_left;
  bit          m_wait;
  int          m_wait_cycles;
  bit          m_err;
  logic [31:0] m_perf_stall;
  logic [31:0] m_perf_flush;

  outs_t       exp_o;
  logic [31:0] exp_tgt;
  bit          took_miss;
  bit          took_redir;
  bit          took_lu;

  function automatic outs_t dut_outs();
    outs_t o;
    o.pc_redirect = bus.pc_redirect;
    o.stall_if    = bus.stall_if;
    o.stall_id    = bus.stall_id;
    o.stall_ex    = bus.stall_ex;
    o.flush_id    = bus.flush_id;
    o.bubble_ex   = bus.bubble_ex;
    o.mem_err     = bus.mem_err;
    return o;
  endfunction

  task automatic model_clear();
    m_flush_left  = 0;
    m_lu_left     = 0;
    m_wait        = 0;
    m_wait_cycles = 0;
    m_err         = 0;
    m_perf_stall  = '0;
    m_perf_flush  = '0;
  endtask

  task automatic model_eval();
    bit miss, redir, lu;
    exp_o      = '0;
    exp_tgt    = '0;
    took_miss  = 0;
    took_redir = 0;
    took_lu    = 0;
    if (rst_n) begin
      miss  = bus.ex_valid && bus.dmem_req && !bus.dmem_ready;
      redir = bus.ex_valid && (bus.ex_jump || bus.ex_branch || bus.ex_fence_i);
      lu    = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 0) && bus.id_valid &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
      exp_o.mem_err = m_err;
      if (m_wait) begin
        exp_o.stall_if = !bus.dmem_ready;
        exp_o.stall_id = !bus.dmem_ready;
        exp_o.stall_ex = !bus.dmem_ready;
      end else if (m_flush_left > 0) begin
        exp_o.flush_id  = 1;
        exp_o.bubble_ex = 1;
      end else if (m_lu_left > 0) begin
        exp_o.stall_if  = 1;
        exp_o.stall_id  = 1;
        exp_o.bubble_ex = 1;
      end else if (miss) begin
        took_miss = 1;
        exp_o.stall_if = 1;
        exp_o.stall_id = 1;
        exp_o.stall_ex = 1;
      end else if (redir) begin
        took_redir = 1;
        exp_o.pc_redirect = 1;
        exp_o.flush_id    = 1;
        exp_o.bubble_ex   = 1;
        exp_tgt = (bus.ex_fence_i ? bus.ex_pc + 32'd4 : bus.ex_target) & ~32'd1;
      end else if (lu) begin
        took_lu = 1;
        exp_o.stall_if  = 1;
        exp_o.stall_id  = 1;
        exp_o.bubble_ex = 1;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst_n) begin
      if (exp_o.stall_if) m_perf_stall = m_perf_stall + 1;
      if (took_redir)     m_perf_flush = m_perf_flush + 1;
      if (m_wait) begin
        m_wait_cycles++;
        if (MEM_TIMEOUT != 0 && m_wait_cycles >= MEM_TIMEOUT) m_err = 1;
        if (bus.dmem_ready) m_wait = 0;
      end else if (m_flush_left > 0) m_flush_left--;
      else if (m_lu_left > 0) m_lu_left--;
      else if (took_miss) begin
        m_wait = 1;
        m_wait_cycles = 0;
      end else if (took_redir) m_flush_left = FLUSH_CYCLES - 1;
      else if (took_lu) m_lu_left = LU_CYCLES - 1;
    end
    #1;
  endtask

  task automatic idle();
    bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_jump = 0; bus.ex_branch = 0; bus.ex_fence_i = 0;
    bus.ex_target = '0; bus.ex_is_load = 0; bus.ex_rd = '0; bus.id_valid = 0; bus.id_rs1 = '0;
    bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
  endtask

  task automatic cmp_model(input string name);
    n_checks++;
    if (dut_outs() !== exp_o)
      $display("FAIL %s: outs got %b want %b (redir,sif,sid,sex,fl,bub,err) t=%0t", name, dut_outs(), exp_o, $time);
    else n_pass++;
  endtask

  task automatic cmp_target(input string name);
    n_checks++;
    if (bus.pc_target !== exp_tgt)
      $display("FAIL %s: pc_target got %h want %h", name, bus.pc_target, exp_tgt);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset();
    idle();
    bus.ex_valid = 1; bus.ex_jump = 1; bus.ex_target = 32'h1234_5678; bus.dmem_req = 1;
    settle();
    n_checks++;
    if (dut_outs() !== '0 || bus.pc_target !== '0)
      $display("FAIL reset_outputs: got %b tgt %h want 0 tgt 0", dut_outs(), bus.pc_target);
    else n_pass++;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    settle();
    cmp_model("after_reset_idle");
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0)
      $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_branch();
    idle();
    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_target = 32'h0000_0101; bus.ex_pc = 32'h0000_00f0;
    settle();
    cmp_model("beq_detect");
    n_checks++;
    if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h100 || bus.flush_id !== 1'b1)
      $display("FAIL beq_target: redir %b tgt %h flush %b want 1 00000100 1", bus.pc_redirect, bus.pc_target, bus.flush_id);
    else n_pass++;
    tick();
    // Exec still shows a taken branch; FLUSH must ignore it.
    settle();
    cmp_model("beq_flush_cycle");
    n_checks++;
    if (bus.pc_redirect !== 1'b0 || bus.flush_id !== 1'b1)
      $display("FAIL beq_flush2: redir %b flush %b want 0 1", bus.pc_redirect, bus.flush_id);
    else n_pass++;
    tick();
    idle();
    settle();
    cmp_model("beq_back_to_run");
    tick();
  endtask

  task automatic test_load_use();
    idle();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd5;
    bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1;
    settle();
    cmp_model("lu_hit");
    n_checks++;
    if ({bus.stall_if, bus.stall_id, bus.bubble_ex, bus.stall_ex} !== 4'b1110)
      $display("FAIL lu_hit_bits: got %b want 1110", {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.stall_ex});
    else n_pass++;
    tick();
    idle();
    settle();
    cmp_model("lu_released");
    tick();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd0;
    bus.id_valid = 1; bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1;
    settle();
    cmp_model("lu_x0");
    n_checks++;
    if (bus.stall_if !== 1'b0 || bus.bubble_ex !== 1'b0)
      $display("FAIL lu_x0_bits: stall_if %b bubble %b want 0 0", bus.stall_if, bus.bubble_ex);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    int high = 0;
    idle();
    bus.ex_valid = 1; bus.dmem_req = 1; bus.ex_jump = 1; bus.ex_target = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      settle();
      cmp_model("mem_wait_cycle");
      if (bus.stall_ex === 1'b1) high++;
      tick();
    end
    n_checks++;
    if (high != 3) $display("FAIL mem_wait_len: stall_ex high %0d cycles want 3", high);
    else n_pass++;
    // Back in RUN: the jump held on the bus is evaluated now.
    bus.dmem_req = 0;
    settle();
    cmp_model("mem_then_redirect");
    cmp_target("mem_then_redirect_tgt");
    tick();
    idle();
    settle();
    cmp_model("mem_redirect_flush");
    tick();
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== m_perf_stall || perf_flush_cnt !== m_perf_flush)
      $display("FAIL perf_cases_1_3: got %0d/%0d want %0d/%0d", perf_stall_cnt, perf_flush_cnt, m_perf_stall, m_perf_flush);
    else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    idle();
    bus.ex_valid = 1; bus.ex_jump = 1; bus.ex_target = 32'h0000_0300; bus.ex_is_load = 1; bus.ex_rd = 5'd7;
    bus.id_valid = 1; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1;
    settle();
    cmp_model("jal_plus_lu");
    n_checks++;
    if (bus.pc_redirect !== 1'b1 || bus.stall_if !== 1'b0 || bus.flush_id !== 1'b1)
      $display("FAIL jal_lu_bits: redir %b stall_if %b flush %b want 1 0 1", bus.pc_redirect, bus.stall_if, bus.flush_id);
    else n_pass++;
    tick();
    idle();
    tick();
    bus.ex_valid = 1; bus.ex_fence_i = 1; bus.ex_pc = 32'h40; bus.ex_target = 32'hdead_beef;
    settle();
    cmp_model("fence_i");
    n_checks++;
    if (bus.pc_target !== 32'h44) $display("FAIL fence_i_target: got %h want 00000044", bus.pc_target);
    else n_pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_timeout();
    int first_err = -1;
    idle();
    bus.ex_valid = 1; bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      cmp_model("timeout_cycle");
      if (bus.mem_err === 1'b1 && first_err < 0) first_err = i;
      tick();
    end
    n_checks++;
    if (first_err != 5) $display("FAIL timeout_rise: first mem_err cycle %0d want 5", first_err);
    else n_pass++;
    bus.dmem_ready = 1;
    tick();
    idle();
    settle();
    n_checks++;
    if (bus.mem_err !== 1'b1) $display("FAIL timeout_sticky: mem_err %b want 1", bus.mem_err);
    else n_pass++;
    apply_reset();
    settle();
    n_checks++;
    if (bus.mem_err !== 1'b0) $display("FAIL timeout_clear: mem_err %b want 0", bus.mem_err);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_flush();
    idle();
    bus.ex_valid = 1; bus.ex_branch = 1; bus.ex_target = 32'h0000_0800;
    tick();
    idle();
    settle();
    cmp_model("in_flush");
    apply_reset();
    settle();
    n_checks++;
    if (dut_outs() !== '0 || bus.pc_target !== '0)
      $display("FAIL reset_mid_flush: got %b tgt %h want 0", dut_outs(), bus.pc_target);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.ex_valid = 1; bus.ex_pc = 32'h0000_0900; bus.id_valid = 1;
    settle();
    n_checks++;
    if ({bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.bubble_ex} !== 5'b0)
      $display("FAIL post_reset_plain: got %b want 00000", {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.bubble_ex});
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.ex_valid   = ($urandom_range(0, 9) < 8);
      bus.ex_pc      = $urandom() & 32'hFFFF_FFFC;
      bus.ex_jump    = ($urandom_range(0, 9) == 0);
      bus.ex_branch  = ($urandom_range(0, 9) == 0);
      bus.ex_fence_i = ($urandom_range(0, 19) == 0);
      bus.ex_target  = $urandom();
      bus.ex_is_load = ($urandom_range(0, 9) < 4);
      bus.ex_rd      = 5'($urandom_range(0, 7));
      bus.id_valid   = ($urandom_range(0, 9) < 8);
      bus.id_rs1     = 5'($urandom_range(0, 7));
      bus.id_rs2     = 5'($urandom_range(0, 7));
      bus.id_use_rs1 = $urandom_range(0, 1) == 1;
      bus.id_use_rs2 = $urandom_range(0, 1) == 1;
      bus.dmem_req   = ($urandom_range(0, 9) < 3);
      bus.dmem_ready = ($urandom_range(0, 9) < 6);
      settle();
      cmp_model("random");
      if (exp_o.pc_redirect) cmp_target("random_target");
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== m_perf_stall || perf_flush_cnt !== m_perf_flush)
      $display("FAIL perf_random: got %0d/%0d want %0d/%0d", perf_stall_cnt, perf_flush_cnt, m_perf_stall, m_perf_flush);
    else n_pass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_branch();
    test_load_use();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
